// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO select serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sel_bit_mux.sv
// Combinational WIDTH:1 bit mux: picks data[sel].
module sel_bit_mux #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_o
);

  always_comb begin
    bit_o = data[sel];
  end

endmodule

// File: rtl/piso_sel_serializer.sv
// Parallel-in/serial-out stage that drives the 8:1 mux select and emits data[sel] LSB first.
// Optional macro SERIAL_PARITY_EN appends one even-parity beat after the data bits.
module piso_sel_serializer
  import piso_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               mux_bit;

  sel_bit_mux #(.WIDTH(WIDTH)) u_sel_bit_mux (
    .data  (data_q),
    .sel   (sel_q),
    .bit_o (mux_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    unique case (state_q)
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = mux_bit;
`ifdef SERIAL_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = (sel_q == SEL_MAX);
`endif
      end
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = ^data_q;
        ser_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    sel        = sel_q;
    load_ready = (state_q == IDLE) | (ser_valid & ser_ready & ser_last);
  end

  // A load on the final-beat handshake overrides the return to IDLE, so words chain with no gap.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      SHIFT: begin
        if (ser_ready) begin
          if (sel_q == SEL_MAX) begin
`ifdef SERIAL_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (ser_ready) state_d = IDLE;
      end
      default: ;
    endcase
    if (load_valid && load_ready) begin
      data_d  = load_data;
      sel_d   = '0;
      state_d = SHIFT;
    end
  end

endmodule
